// File: rtl/mcycle_bus_engine_if.sv
// Bus bundle between requesters (CPU, DMA), the M-cycle engine and the memory slave.
// The engine is the bus master towards the slave side.
interface mcycle_bus_engine_if #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int NUM_CH  = 2,
  parameter int T_PER_M = 4
);
  localparam int PW = $clog2(T_PER_M);

  logic                     stall;
  logic [NUM_CH-1:0]        req;
  logic [NUM_CH-1:0]        we;
  logic [NUM_CH*ADDR_W-1:0] addr;
  logic [NUM_CH*DATA_W-1:0] wdata;
  logic [NUM_CH-1:0]        gnt;
  logic [NUM_CH-1:0]        done;
  logic                     err;
  logic [DATA_W-1:0]        rdata;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic                     mem_rd;
  logic                     mem_wr;
  logic [DATA_W-1:0]        mem_rdata;
  logic                     mem_wait;
  logic [PW-1:0]            t_phase;
  logic                     m_strobe;
  logic                     busy;

  modport master (
    input  stall, req, we, addr, wdata, mem_rdata, mem_wait,
    output gnt, done, err, rdata, mem_addr, mem_wdata, mem_rd, mem_wr,
           t_phase, m_strobe, busy
  );

  modport slave (
    output stall, req, we, addr, wdata, mem_rdata, mem_wait,
    input  gnt, done, err, rdata, mem_addr, mem_wdata, mem_rd, mem_wr,
           t_phase, m_strobe, busy
  );
endinterface

// File: rtl/mcycle_bus_engine.sv
// T-phase/M-cycle sequencer with fixed-priority arbitration, one bus access
// per M-cycle, slave wait states with timeout, and a phase-0 stall.
module mcycle_bus_engine #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int NUM_CH   = 2,
  parameter int T_PER_M  = 4,
  parameter int MAX_WAIT = 3
) (
  input logic                clk,
  input logic                rst,
  mcycle_bus_engine_if.master bus
);
  localparam int PW = $clog2(T_PER_M);
  localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [PW-1:0] PH_WAIT = PW'(T_PER_M - 2);
  localparam logic [PW-1:0] PH_LAST = PW'(T_PER_M - 1);
  localparam logic [WW-1:0] WAIT_LIM = WW'(MAX_WAIT);

  typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              win_valid;
  logic [CW-1:0]     win_id;
  logic              grant_ok;
  logic              access;

  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (bus.req[i] && !win_valid) begin
        win_valid = 1'b1;
        win_id    = CW'(i);
      end
    end
  end

  assign grant_ok = (phase_q == '0) && !bus.stall && !rst && win_valid;
  assign access   = (state_q == ST_ACCESS);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    wait_cnt_d = wait_cnt_q;
    ch_d       = ch_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    if (phase_q == '0) begin
      if (!bus.stall) begin
        phase_d = PW'(1);
        if (win_valid) begin
          state_d = ST_ACCESS;
          ch_d    = win_id;
          we_d    = bus.we[win_id];
          addr_d  = bus.addr[int'(win_id)*ADDR_W +: ADDR_W];
          wdata_d = bus.wdata[int'(win_id)*DATA_W +: DATA_W];
        end
      end
    end else if (phase_q == PH_WAIT && access) begin
      // Wait states hold the phase; the edge after the limit is a timeout.
      if (bus.mem_wait && wait_cnt_q < WAIT_LIM) begin
        wait_cnt_d = wait_cnt_q + WW'(1);
      end else begin
        phase_d = PH_LAST;
        if (bus.mem_wait) err_d = 1'b1;
        else if (!we_q)   rdata_d = bus.mem_rdata;
      end
    end else if (phase_q == PH_LAST) begin
      phase_d    = '0;
      wait_cnt_d = '0;
      state_d    = ST_IDLE;
      err_d      = 1'b0;
    end else begin
      phase_d = phase_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      wait_cnt_q <= '0;
      ch_q       <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      wait_cnt_q <= wait_cnt_d;
      ch_q       <= ch_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    bus.gnt  = '0;
    bus.done = '0;
    if (grant_ok) bus.gnt[win_id] = 1'b1;
    if (access && phase_q == PH_LAST) bus.done[ch_q] = 1'b1;
  end

  assign bus.mem_rd    = access && (phase_q != PH_LAST) && !we_q;
  assign bus.mem_wr    = access && (phase_q != PH_LAST) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rdata     = rdata_q;
  assign bus.err       = err_q;
  assign bus.t_phase   = phase_q;
  assign bus.m_strobe  = (phase_q == PH_LAST);
  assign bus.busy      = access;
endmodule

// File: tb/tb_mcycle_bus_engine.sv
// Self-checking bench for mcycle_bus_engine: directed scenarios plus random
// M-cycles checked against a transaction-level timing model.
module tb_mcycle_bus_engine;
  localparam int T  = 4;
  localparam int MW = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_gnt_cyc = 0;
  int   last_done_cyc = 0;
  logic [7:0] rd_model = 8'h00;

  mcycle_bus_engine_if #(.ADDR_W(16), .DATA_W(8), .NUM_CH(2), .T_PER_M(T)) bus ();

  mcycle_bus_engine #(
    .ADDR_W(16), .DATA_W(8), .NUM_CH(2), .T_PER_M(T), .MAX_WAIT(MW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One M-cycle starting in phase 0. waits = cycles the slave asserts mem_wait
  // once the access reaches its last strobe phase.
  task automatic m_cycle(input logic [1:0] mask, input logic [1:0] wev,
                         input logic [15:0] a0, input logic [15:0] a1,
                         input logic [7:0] d0, input logic [7:0] d1,
                         input int waits, input logic [7:0] rv,
                         input int stall_n, input bit stall_mid);
    int w, e, last, exp_ph;
    bit to, wl;
    logic [15:0] al;
    logic [7:0] dl;
    logic [1:0] oh;
    bus.req = mask; bus.we = wev;
    bus.addr = {a1, a0}; bus.wdata = {d1, d0};
    bus.mem_wait = 1'b0; bus.mem_rdata = rv;
    for (int s = 0; s < stall_n; s++) begin
      bus.stall = 1'b1;
      #1;
      chk("stall_phase", 32'(bus.t_phase), 0);
      chk("stall_gnt", 32'(bus.gnt), 0);
      chk("stall_mstrobe", 32'(bus.m_strobe), 0);
      tick();
    end
    bus.stall = 1'b0;
    #1;
    w  = mask[0] ? 0 : (mask[1] ? 1 : -1);
    oh = (w < 0) ? 2'b00 : 2'(1 << w);
    chk("gnt", 32'(bus.gnt), 32'(oh));
    chk("ph0_phase", 32'(bus.t_phase), 0);
    chk("ph0_done", 32'(bus.done), 0);
    if (w >= 0) last_gnt_cyc = cyc;
    wl = (w >= 0) ? wev[w] : 1'b0;
    al = (w == 1) ? a1 : a0;
    dl = (w == 1) ? d1 : d0;
    tick();
    if (w >= 0) bus.req[w] = 1'b0;
    if (w < 0) begin
      for (int k = 1; k < T; k++) begin
        bus.stall = stall_mid;
        bus.mem_wait = 1'($urandom_range(0, 1));
        #1;
        chk("idle_phase", 32'(bus.t_phase), 32'(k));
        chk("idle_strobes", {bus.mem_rd, bus.mem_wr, bus.busy}, 0);
        chk("idle_done", 32'(bus.done), 0);
        chk("idle_mstrobe", 32'(bus.m_strobe), 32'(k == T - 1));
        bus.stall = 1'b0;
        tick();
      end
      bus.mem_wait = 1'b0;
      return;
    end
    e    = (waits > MW) ? MW : waits;
    to   = (waits > MW);
    last = T - 1 + e;
    for (int k = 1; k <= last; k++) begin
      bus.stall    = stall_mid;
      bus.mem_wait = (k >= T - 2 && k < T - 2 + waits);
      #1;
      exp_ph = (k < T - 2) ? k : ((k == last) ? T - 1 : T - 2);
      chk("acc_phase", 32'(bus.t_phase), 32'(exp_ph));
      if (k < last) begin
        chk("acc_rd", 32'(bus.mem_rd), 32'(!wl));
        chk("acc_wr", 32'(bus.mem_wr), 32'(wl));
        chk("acc_addr", 32'(bus.mem_addr), 32'(al));
        if (wl) chk("acc_wdata", 32'(bus.mem_wdata), 32'(dl));
        chk("acc_done", 32'(bus.done), 0);
        chk("acc_busy", 32'(bus.busy), 1);
        chk("acc_rdata_hold", 32'(bus.rdata), 32'(rd_model));
      end else begin
        if (!wl && !to) rd_model = rv;
        chk("end_strobes", {bus.mem_rd, bus.mem_wr}, 0);
        chk("end_done", 32'(bus.done), 32'(oh));
        chk("end_err", 32'(bus.err), 32'(to));
        chk("end_mstrobe", 32'(bus.m_strobe), 1);
        chk("end_rdata", 32'(bus.rdata), 32'(rd_model));
        last_done_cyc = cyc;
      end
      bus.stall = 1'b0;
      tick();
    end
    bus.mem_wait = 1'b0;
  endtask

  initial begin
    int g0;
    rst = 1'b1;
    bus.stall = 1'b0; bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
    bus.mem_rdata = '0; bus.mem_wait = 1'b0;
    tick(); tick();
    chk("rst_phase", 32'(bus.t_phase), 0);
    chk("rst_outs", {bus.gnt, bus.done, bus.err, bus.mem_rd, bus.mem_wr, bus.m_strobe, bus.busy}, 0);
    chk("rst_rdata", 32'(bus.rdata), 0);
    chk("rst_maddr", 32'(bus.mem_addr), 0);
    rst = 1'b0;

    // ch1 read
    m_cycle(2'b10, 2'b00, 16'h0000, 16'hC000, 8'h00, 8'h00, 0, 8'h5A, 0, 0);
    chk("t1_latency", 32'(last_done_cyc - last_gnt_cyc), 32'(T - 1));
    // ch0 write beats ch1 read; ch1 follows in the next M-cycle
    m_cycle(2'b11, 2'b01, 16'hFE00, 16'hFF44, 8'h12, 8'h00, 0, 8'h5A, 0, 0);
    g0 = last_gnt_cyc;
    m_cycle(2'b10, 2'b01, 16'hFE00, 16'hFF44, 8'h12, 8'h00, 0, 8'h5A, 0, 0);
    chk("t2_gnt0_to_done1", 32'(last_done_cyc - g0), 7);
    // two wait states
    m_cycle(2'b01, 2'b00, 16'h1234, 16'h0, 8'h0, 8'h0, 2, 8'h5A, 0, 0);
    chk("t3_latency", 32'(last_done_cyc - last_gnt_cyc), 5);
    // stuck wait -> timeout, rdata must keep 0x5A
    m_cycle(2'b01, 2'b00, 16'h2000, 16'h0, 8'h0, 8'h0, 20, 8'hEE, 0, 0);
    chk("t4_latency", 32'(last_done_cyc - last_gnt_cyc), 6);
    chk("t4_rdata", 32'(bus.rdata), 32'h5A);
    // stall at phase 0, then stall during a running access
    m_cycle(2'b01, 2'b00, 16'h3000, 16'h0, 8'h0, 8'h0, 0, 8'h33, 5, 0);
    m_cycle(2'b01, 2'b01, 16'h3001, 16'h0, 8'h44, 8'h0, 0, 8'h00, 0, 1);
    m_cycle(2'b00, 2'b00, 16'h0, 16'h0, 8'h0, 8'h0, 0, 8'h00, 0, 0);

    // reset during phase 2 of a ch0 write
    bus.req = 2'b01; bus.we = 2'b01; bus.addr = {16'h0, 16'h8000}; bus.wdata = {8'h0, 8'hAB};
    #1;
    chk("t6_gnt", 32'(bus.gnt), 1);
    tick();
    bus.req = '0;
    tick();
    #1;
    chk("t6_wr_before", 32'(bus.mem_wr), 1);
    chk("t6_phase_before", 32'(bus.t_phase), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    rd_model = 8'h00;
    chk("t6_wr", 32'(bus.mem_wr), 0);
    chk("t6_phase", 32'(bus.t_phase), 0);
    chk("t6_done_err", {bus.done, bus.err}, 0);
    chk("t6_rdata", 32'(bus.rdata), 0);

    for (int n = 0; n < 40; n++) begin
      m_cycle(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
              int'($urandom_range(0, 5)), 8'($urandom),
              int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
